// File: rtl/tx_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_ser_pkg
// Purpose : Shared types and constants for the transmit bit serializer.
//           Holds the serializer state enum and the CRC-16/CCITT-FALSE
//           polynomial and seed.
// Ports   : none (package)
// Config  : TX_SER_CRC_EN selects the CRC logic in the users of this package.
// Revision: 1.0 - initial release
// ============================================================================
package tx_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage : tx_ser_pkg
`default_nettype wire

// File: rtl/crc16_ccitt_bit.sv
`default_nettype none
// ============================================================================
// Module  : crc16_ccitt_bit
// Purpose : One-bit update of a CRC-16/CCITT register (poly 0x1021,
//           MSB-first, no reflection). Passes crc_i through when en_i is low.
// Ports   : crc_i [15:0]  current CRC register value
//           bit_i         serial data bit to absorb
//           en_i          update enable
//           crc_o [15:0]  updated CRC value
// Config  : used only when TX_SER_CRC_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module crc16_ccitt_bit
  import tx_ser_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic        bit_i,
  input  logic        en_i,
  output logic [15:0] crc_o
);

  logic        feedback;
  logic [15:0] shifted;

  assign feedback = crc_i[15] ^ bit_i;
  assign shifted  = {crc_i[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
  assign crc_o    = en_i ? shifted : crc_i;

endmodule : crc16_ccitt_bit
`default_nettype wire

// File: rtl/tx_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tx_bit_serializer
// Purpose : Accepts words over a valid/ready handshake and shifts them out
//           MSB-first on ser_out_o, each bit held CLKS_PER_BIT cycles. After a
//           word flagged tx_last_i an idle gap of GAP_BITS bit-times follows,
//           and frame_done_o pulses on its final cycle.
// Ports   : clk_i, rst_ni (async active-low)
//           tx_valid_i, tx_data_i[DATA_W-1:0], tx_last_i, tx_ready_o
//           ser_out_o, bit_strobe_o, busy_o, frame_done_o
//           crc_value_o[15:0] (only with TX_SER_CRC_EN)
// Config  : define TX_SER_CRC_EN to add a running CRC-16/CCITT-FALSE over
//           the transmitted data bits of each frame.
// Revision: 1.0 - initial release
// ============================================================================
module tx_bit_serializer
  import tx_ser_pkg::*;
#(
  parameter int   DATA_W       = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter int   GAP_BITS     = 2,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  output logic              tx_ready_o,
  output logic              ser_out_o,
  output logic              bit_strobe_o,
  output logic              busy_o,
  output logic              frame_done_o
`ifdef TX_SER_CRC_EN
  ,
  output logic [15:0]       crc_value_o
`endif
);

  localparam int GAP_LEN = GAP_BITS * CLKS_PER_BIT;
  localparam int TICK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);
  // Gap count one cycle before the last gap cycle; frame_done is registered.
  localparam logic [GAP_W-1:0]  GAP_PRE   = GAP_W'(GAP_LEN - 2);

  tx_state_e          state_q;
  logic [DATA_W-1:0]  shreg_q;
  logic [DATA_W-1:0]  shreg_d;
  logic               last_q;
  logic [TICK_W-1:0]  tick_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               tx_ready_q;
  logic               ser_out_q;
  logic               bit_strobe_q;
  logic               frame_done_q;
  logic               handshake;

  assign shreg_d   = shreg_q << 1;
  assign handshake = (state_q == IDLE) && tx_valid_i && tx_ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tx_ready_q   <= 1'b0;
      ser_out_q    <= IDLE_LEVEL;
      bit_strobe_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_done_q <= 1'b0;
          if (handshake) begin
            // First bit goes out on the very next cycle.
            shreg_q      <= tx_data_i;
            last_q       <= tx_last_i;
            tx_ready_q   <= 1'b0;
            ser_out_q    <= tx_data_i[DATA_W-1];
            bit_strobe_q <= 1'b1;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            state_q      <= SHIFT;
          end else begin
            // Also raises ready on the first edge after reset release.
            tx_ready_q   <= 1'b1;
            ser_out_q    <= IDLE_LEVEL;
            bit_strobe_q <= 1'b0;
          end
        end

        SHIFT: begin
          frame_done_q <= 1'b0;
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q    <= '0;
              ser_out_q    <= IDLE_LEVEL;
              bit_strobe_q <= 1'b0;
              if (last_q) begin
                state_q      <= GAP;
                gap_cnt_q    <= '0;
                frame_done_q <= (GAP_LEN == 1);
              end else begin
                state_q    <= IDLE;
                tx_ready_q <= 1'b1;
              end
            end else begin
              shreg_q      <= shreg_d;
              ser_out_q    <= shreg_d[DATA_W-1];
              bit_strobe_q <= 1'b1;
              bit_cnt_q    <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_q       <= tick_q + TICK_W'(1);
            bit_strobe_q <= 1'b0;
          end
        end

        GAP: begin
          ser_out_q    <= IDLE_LEVEL;
          bit_strobe_q <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            tx_ready_q   <= 1'b1;
            state_q      <= IDLE;
          end else begin
            gap_cnt_q    <= gap_cnt_q + GAP_W'(1);
            frame_done_q <= (gap_cnt_q == GAP_PRE);
          end
        end

        default: begin
          state_q      <= IDLE;
          ser_out_q    <= IDLE_LEVEL;
          bit_strobe_q <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready_o   = tx_ready_q;
  assign ser_out_o    = ser_out_q;
  assign bit_strobe_o = bit_strobe_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != IDLE);

`ifdef TX_SER_CRC_EN
  logic        first_q;   // next accepted word starts a new frame
  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // The bit on the line during its strobe cycle is absorbed at the end of it.
  crc16_ccitt_bit u_crc (
    .crc_i (crc_q),
    .bit_i (ser_out_q),
    .en_i  (bit_strobe_q),
    .crc_o (crc_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q   <= CRC16_INIT;
      first_q <= 1'b1;
    end else begin
      if (handshake) begin
        first_q <= 1'b0;
        if (first_q) begin
          crc_q <= CRC16_INIT;
        end
      end else begin
        crc_q <= crc_d;
        if (frame_done_q) begin
          first_q <= 1'b1;
        end
      end
    end
  end

  assign crc_value_o = crc_q;
`endif

endmodule : tx_bit_serializer
`default_nettype wire

// File: tb/tb_tx_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_bit_serializer
// Purpose : Self-checking bench for tx_bit_serializer. A timeline model
//           derives every expected output from the cycle offset since the
//           accepting handshake; directed and random words are driven.
// Ports   : none
// Config  : define TX_SER_CRC_EN to also check crc_value_o.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tx_bit_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int GB  = 2;
  localparam int NB  = DW * CPB;   // data cycles per word
  localparam int NG  = GB * CPB;   // gap cycles after a last word

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, ser_out, bit_strobe, busy, frame_done;
`ifdef TX_SER_CRC_EN
  logic [15:0] crc_value;
`endif

  always #5 clk = ~clk;

  tx_bit_serializer #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .GAP_BITS     (GB),
    .IDLE_LEVEL   (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_last_i    (tx_last),
    .tx_ready_o   (tx_ready),
    .ser_out_o    (ser_out),
    .bit_strobe_o (bit_strobe),
    .busy_o       (busy),
    .frame_done_o (frame_done)
`ifdef TX_SER_CRC_EN
    ,
    .crc_value_o  (crc_value)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: timeline position of the word in flight.
  bit         m_active = 1'b0;
  bit         m_ready  = 1'b0;
  bit         m_last   = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_word   = 8'h00;
`ifdef TX_SER_CRC_EN
  bit          m_first      = 1'b1;
  bit          m_word_first = 1'b0;
  logic [15:0] m_crc        = 16'hFFFF;
`endif

  int obs_strobes   = 0;
  int obs_ready_low = 0;
  int obs_done      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

`ifdef TX_SER_CRC_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction
`endif

  function automatic int word_len();
    return NB + (m_last ? NG : 0);
  endfunction

  task automatic check_outputs();
    logic e_ser, e_strobe, e_done, e_busy;
    e_ser = 1'b1; e_strobe = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    if (rst_ni && m_active) begin
      e_busy = 1'b1;
      if (m_k <= NB) begin
        e_ser    = m_word[DW - 1 - (m_k - 1) / CPB];
        e_strobe = ((m_k - 1) % CPB) == 0;
      end else begin
        e_done = m_last && (m_k == NB + NG);
      end
    end
    check_eq("ser_out", ser_out, e_ser);
    check_eq("bit_strobe", bit_strobe, e_strobe);
    check_eq("frame_done", frame_done, e_done);
    check_eq("busy", busy, e_busy);
    check_eq("tx_ready", tx_ready, m_ready);
`ifdef TX_SER_CRC_EN
    if (!rst_ni) check_eq("crc_reset", crc_value, 16'hFFFF);
    if (m_active && m_k == 1 && m_word_first) check_eq("crc_reload", crc_value, 16'hFFFF);
    if (e_done) check_eq("crc_at_done", crc_value, m_crc);
`endif
    obs_strobes   += int'(bit_strobe);
    obs_ready_low += int'(!tx_ready);
    obs_done      += int'(frame_done);
  endtask

  // One clock: predict the handshake, advance the model, check after the edge.
  task automatic tick(output bit hs_o);
    hs_o = tx_valid && m_ready && rst_ni;
    @(posedge clk);
    if (rst_ni) begin
      if (m_active) begin
        m_k++;
        if (m_k > word_len()) begin
          m_active = 1'b0;
          m_ready  = 1'b1;
`ifdef TX_SER_CRC_EN
          if (m_last) m_first = 1'b1;
`endif
        end
      end else if (hs_o) begin
        m_active = 1'b1;
        m_k      = 1;
        m_ready  = 1'b0;
        m_word   = tx_data;
        m_last   = tx_last;
`ifdef TX_SER_CRC_EN
        m_word_first = m_first;
        if (m_first) m_crc = 16'hFFFF;
        m_first = 1'b0;
        m_crc   = crc_byte(m_crc, tx_data);
`endif
      end else begin
        m_ready = 1'b1;
      end
    end
    #1 check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    bit hs;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  task automatic send_word(input logic [7:0] d, input bit last);
    bit hs;
    hs       = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    for (int i = 0; i < 200 && !hs; i++) tick(hs);
    check_eq("hs_wait", hs, 1'b1);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_active; i++) idle_cycles(1);
    check_eq("idle_wait", m_active, 1'b0);
  endtask

  // Reset is asserted just after a rising edge, i.e. asynchronously.
  task automatic apply_reset(input int n);
    rst_ni   = 1'b0;
    m_active = 1'b0;
    m_ready  = 1'b0;
`ifdef TX_SER_CRC_EN
    m_first  = 1'b1;
`endif
    #1 check_outputs();
    idle_cycles(n);
    rst_ni = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    // 1. reset for 5 cycles, ready one edge after release
    @(posedge clk);
    apply_reset(5);
    tick(hs);
    check_eq("ready_after_release", tx_ready, 1'b1);

    // 2. single non-last word 0xA5
    obs_strobes = 0; obs_ready_low = 0; obs_done = 0;
    send_word(8'hA5, 1'b0);
    wait_idle();
    idle_cycles(2);
    check_eq("a5_strobes", obs_strobes, 8);
    check_eq("a5_ready_low", obs_ready_low, NB);
    check_eq("a5_frame_done", obs_done, 0);

    // 3. back-to-back 0x3C then 0xC3 (last) with tx_valid held high
    obs_strobes = 0; obs_done = 0;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b1);
    wait_idle();
    idle_cycles(2);
    check_eq("b2b_strobes", obs_strobes, 16);
    check_eq("b2b_frame_done", obs_done, 1);

    // 4. reset during bit 3 of 0xFF, then 0x00 normally
    send_word(8'hFF, 1'b1);
    while (m_k < 14) idle_cycles(1);
    obs_strobes = 0; obs_done = 0;
    apply_reset(3);
    idle_cycles(3);
    check_eq("rst_no_strobe", obs_strobes, 0);
    check_eq("rst_no_done", obs_done, 0);
    obs_strobes = 0;
    send_word(8'h00, 1'b1);
    wait_idle();
    check_eq("post_rst_strobes", obs_strobes, 8);
    check_eq("post_rst_done", obs_done, 1);

    // 5. random words with random 0-10 cycle upstream pauses
    for (int w = 0; w < 25; w++) begin
      idle_cycles($urandom_range(0, 10));
      send_word(8'($urandom), ($urandom_range(0, 3) == 0));
    end
    send_word(8'($urandom), 1'b1);
    wait_idle();

`ifdef TX_SER_CRC_EN
    // 6. "123456789" frame, then a fresh frame reloads the seed
    for (int c = 0; c < 9; c++) send_word(8'(8'h31 + c), (c == 8));
    wait_idle();
    idle_cycles(3);
    check_eq("crc_check_value", crc_value, 16'h29B1);
    send_word(8'h5A, 1'b1);
    wait_idle();
`endif

    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tx_bit_serializer
`default_nettype wire
